// File: rtl/mem_stage_top.sv
// MEM pipeline stage: WB-to-store forwarding, word/half/byte data memory,
// address-exception detection and the MEM/WB register.
package mem_stage_pkg;
    localparam int WIDTH_INSTR = 6;
    localparam int WIDTH_T     = 2;

    localparam logic [WIDTH_INSTR-1:0] I_NOP = 6'd0;
    localparam logic [WIDTH_INSTR-1:0] I_ALU = 6'd1;
    localparam logic [WIDTH_INSTR-1:0] I_LW  = 6'd2;
    localparam logic [WIDTH_INSTR-1:0] I_LH  = 6'd3;
    localparam logic [WIDTH_INSTR-1:0] I_LHU = 6'd4;
    localparam logic [WIDTH_INSTR-1:0] I_LB  = 6'd5;
    localparam logic [WIDTH_INSTR-1:0] I_LBU = 6'd6;
    localparam logic [WIDTH_INSTR-1:0] I_SW  = 6'd7;
    localparam logic [WIDTH_INSTR-1:0] I_SH  = 6'd8;
    localparam logic [WIDTH_INSTR-1:0] I_SB  = 6'd9;

    localparam logic [6:2] EXC_NONE = 5'd0;
    localparam logic [6:2] EXC_ADEL = 5'd4;
    localparam logic [6:2] EXC_ADES = 5'd5;
endpackage

module mem_stage_top
    import mem_stage_pkg::*;
#(
    parameter int    DM_WORDS = 4096,
    parameter string DM_INIT  = ""
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   stall,
    input  logic                   clr,
    input  logic [WIDTH_INSTR-1:0] instr_MEM,
    input  logic [31:0]            PC_MEM,
    input  logic [6:2]             Exc_MEM,
    input  logic [31:0]            aluOut_MEM,
    input  logic [4:0]             addrRt_MEM,
    input  logic [31:0]            dataRt_MEM,
    input  logic [4:0]             regWriteAddr_MEM,
    input  logic [31:0]            regWriteData_MEM,
    input  logic [WIDTH_T-1:0]     Tnew_MEM,
    input  logic [4:0]             regaddr_WB,
    input  logic [31:0]            regdata_WB,
    input  logic                   excReq,
    output logic [4:0]             regaddr_fwd,
    output logic [31:0]            regdata_fwd,
    output logic [WIDTH_INSTR-1:0] instr_WB,
    output logic [31:0]            PC_WB,
    output logic [6:2]             Exc_WB,
    output logic [4:0]             regWriteAddr_WB,
    output logic [31:0]            regWriteData_WB,
    output logic [WIDTH_T-1:0]     Tnew_WB
);

    localparam int AW = $clog2(DM_WORDS);
    localparam logic [32:0] DM_BYTES = 33'(DM_WORDS) << 2;

    logic [31:0] dm [DM_WORDS];

    logic is_lw, is_lh, is_lhu, is_lb, is_lbu;
    logic is_sw, is_sh, is_sb;
    logic is_load, is_store, is_word, is_half;

    always_comb begin
        is_lw  = 1'b0;
        is_lh  = 1'b0;
        is_lhu = 1'b0;
        is_lb  = 1'b0;
        is_lbu = 1'b0;
        is_sw  = 1'b0;
        is_sh  = 1'b0;
        is_sb  = 1'b0;
        unique case (instr_MEM)
            I_LW:    is_lw  = 1'b1;
            I_LH:    is_lh  = 1'b1;
            I_LHU:   is_lhu = 1'b1;
            I_LB:    is_lb  = 1'b1;
            I_LBU:   is_lbu = 1'b1;
            I_SW:    is_sw  = 1'b1;
            I_SH:    is_sh  = 1'b1;
            I_SB:    is_sb  = 1'b1;
            default: ;
        endcase
    end

    assign is_load  = is_lw | is_lh | is_lhu | is_lb | is_lbu;
    assign is_store = is_sw | is_sh | is_sb;
    assign is_word  = is_lw | is_sw;
    assign is_half  = is_lh | is_lhu | is_sh;

    logic [31:0] rt_data;
    assign rt_data = (regaddr_WB == addrRt_MEM && regaddr_WB != 5'd0)
                   ? regdata_WB : dataRt_MEM;

    logic       misalign;
    logic       out_of_range;
    logic       addr_bad;
    logic [6:2] exc;

    assign misalign = (is_word && aluOut_MEM[1:0] != 2'b00)
                    || (is_half && aluOut_MEM[0]);
    // Full 33-bit compare so high address bits can never alias into DM
    assign out_of_range = {1'b0, aluOut_MEM} >= DM_BYTES;
    assign addr_bad     = misalign || out_of_range;

    always_comb begin
        exc = Exc_MEM;
        if (Exc_MEM == EXC_NONE) begin
            if (is_load && addr_bad) begin
                exc = EXC_ADEL;
            end else if (is_store && addr_bad) begin
                exc = EXC_ADES;
            end
        end
    end

    logic [AW-1:0] idx;
    logic [31:0]   rd_word;
    logic [15:0]   rd_half;
    logic [7:0]    rd_byte;

    assign idx     = aluOut_MEM[AW+1:2];
    assign rd_word = dm[idx];
    assign rd_half = aluOut_MEM[1] ? rd_word[31:16] : rd_word[15:0];
    assign rd_byte = rd_word[{aluOut_MEM[1:0], 3'b000} +: 8];

    logic [31:0] load_data;

    always_comb begin
        load_data = 32'd0;
        unique case (1'b1)
            is_lw:   load_data = rd_word;
            is_lh:   load_data = {{16{rd_half[15]}}, rd_half};
            is_lhu:  load_data = {16'd0, rd_half};
            is_lb:   load_data = {{24{rd_byte[7]}}, rd_byte};
            is_lbu:  load_data = {24'd0, rd_byte};
            default: ;
        endcase
    end

    logic        load_fault;
    logic [31:0] wb_data_d;
    logic [4:0]  wb_addr_d;

    assign load_fault = is_load && exc != EXC_NONE;
    assign wb_data_d  = is_load ? (load_fault ? 32'd0 : load_data)
                                : regWriteData_MEM;
    assign wb_addr_d  = load_fault ? 5'd0 : regWriteAddr_MEM;

    logic        dm_we;
    logic [3:0]  dm_be;
    logic [31:0] dm_wdata;

    assign dm_we = is_store && exc == EXC_NONE
                && !excReq && !stall && !clr;

    always_comb begin
        dm_be    = 4'b0000;
        dm_wdata = rt_data;
        unique case (1'b1)
            is_sw: dm_be = 4'b1111;
            is_sh: begin
                dm_be    = aluOut_MEM[1] ? 4'b1100 : 4'b0011;
                dm_wdata = {2{rt_data[15:0]}};
            end
            is_sb: begin
                dm_be    = 4'b0001 << aluOut_MEM[1:0];
                dm_wdata = {4{rt_data[7:0]}};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DM_WORDS; i++) begin
                dm[i] <= '0;
            end
        end else if (dm_we) begin
            for (int b = 0; b < 4; b++) begin
                if (dm_be[b]) begin
                    dm[idx][8*b +: 8] <= dm_wdata[8*b +: 8];
                end
            end
        end
    end

    logic [WIDTH_T-1:0] tnew_d;
    assign tnew_d = (Tnew_MEM != '0) ? Tnew_MEM - WIDTH_T'(1) : '0;

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            instr_WB        <= '0;
            PC_WB           <= '0;
            Exc_WB          <= '0;
            regWriteAddr_WB <= '0;
            regWriteData_WB <= '0;
            Tnew_WB         <= '0;
        end else if (!stall) begin
            instr_WB        <= instr_MEM;
            PC_WB           <= PC_MEM;
            Exc_WB          <= exc;
            regWriteAddr_WB <= wb_addr_d;
            regWriteData_WB <= wb_data_d;
            Tnew_WB         <= tnew_d;
        end
    end

    assign regaddr_fwd = (Tnew_MEM == '0) ? regWriteAddr_MEM : 5'd0;
    assign regdata_fwd = regWriteData_MEM;

endmodule

// File: tb/tb_mem_stage_top.sv
// Scoreboard bench for mem_stage_top: byte-array memory model,
// directed scenarios followed by randomized traffic.
`timescale 1ns/1ps
module tb_mem_stage_top;
    import mem_stage_pkg::*;

    localparam int DMW = 256;
    localparam int NB  = 4 * DMW;

    logic                   clk = 1'b0;
    logic                   reset, stall, clr, excReq;
    logic [WIDTH_INSTR-1:0] instr_MEM;
    logic [31:0]            PC_MEM, aluOut_MEM, dataRt_MEM;
    logic [6:2]             Exc_MEM;
    logic [4:0]             addrRt_MEM, regWriteAddr_MEM, regaddr_WB;
    logic [31:0]            regWriteData_MEM, regdata_WB;
    logic [WIDTH_T-1:0]     Tnew_MEM;
    logic [4:0]             regaddr_fwd;
    logic [31:0]            regdata_fwd;
    logic [WIDTH_INSTR-1:0] instr_WB;
    logic [31:0]            PC_WB;
    logic [6:2]             Exc_WB;
    logic [4:0]             regWriteAddr_WB;
    logic [31:0]            regWriteData_WB;
    logic [WIDTH_T-1:0]     Tnew_WB;

    always #5 clk = ~clk;

    mem_stage_top #(.DM_WORDS(DMW), .DM_INIT("")) dut (
        .clk(clk), .reset(reset), .stall(stall), .clr(clr),
        .instr_MEM(instr_MEM), .PC_MEM(PC_MEM), .Exc_MEM(Exc_MEM),
        .aluOut_MEM(aluOut_MEM), .addrRt_MEM(addrRt_MEM),
        .dataRt_MEM(dataRt_MEM), .regWriteAddr_MEM(regWriteAddr_MEM),
        .regWriteData_MEM(regWriteData_MEM), .Tnew_MEM(Tnew_MEM),
        .regaddr_WB(regaddr_WB), .regdata_WB(regdata_WB),
        .excReq(excReq), .regaddr_fwd(regaddr_fwd),
        .regdata_fwd(regdata_fwd), .instr_WB(instr_WB), .PC_WB(PC_WB),
        .Exc_WB(Exc_WB), .regWriteAddr_WB(regWriteAddr_WB),
        .regWriteData_WB(regWriteData_WB), .Tnew_WB(Tnew_WB)
    );

    typedef struct {
        logic [WIDTH_INSTR-1:0] op;
        logic [31:0]            a, rtd, wd, wbd, pc;
        logic [4:0]             rta, wa, wba;
        logic [WIDTH_T-1:0]     tnew;
        logic [6:2]             exc;
        bit                     stall, clr, xr, rst;
    } stim_t;

    typedef struct {
        logic [WIDTH_INSTR-1:0] instr;
        logic [31:0]            pc, wd, fd;
        logic [6:2]             exc;
        logic [4:0]             wa, fa;
        logic [WIDTH_T-1:0]     tnew;
    } exp_t;

    exp_t       q[$];
    exp_t       last;
    logic [7:0] mdl [NB];
    int         checks = 0;
    int         errors = 0;

    logic [WIDTH_INSTR-1:0] ops [10] = '{I_NOP, I_ALU, I_LW, I_LH, I_LHU,
                                         I_LB, I_LBU, I_SW, I_SH, I_SB};

    task automatic chk(input string n, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at %0t actual=%h required=%h", n, $time, act, req);
        end
    endtask

    function automatic bit is_ld(input logic [WIDTH_INSTR-1:0] op);
        return op inside {I_LW, I_LH, I_LHU, I_LB, I_LBU};
    endfunction

    function automatic stim_t mk(input logic [WIDTH_INSTR-1:0] op,
                                 input logic [31:0] a, input logic [31:0] rtd);
        stim_t s;
        s = '{default: '0};
        s.op   = op;
        s.a    = a;
        s.rtd  = rtd;
        s.pc   = $urandom;
        s.wd   = $urandom;
        s.tnew = WIDTH_T'($urandom_range(0, 3));
        s.wa   = is_ld(op) ? 5'd9 : 5'd0;
        return s;
    endfunction

    // One stimulus cycle: drive at negedge, predict what WB holds after posedge
    task automatic step(input stim_t s);
        exp_t        e;
        int unsigned size, a;
        bit          ld, st, sgn;
        logic [31:0] rt, v;
        @(negedge clk);
        reset            = s.rst;
        stall            = s.stall;
        clr              = s.clr;
        excReq           = s.xr;
        instr_MEM        = s.op;
        PC_MEM           = s.pc;
        Exc_MEM          = s.exc;
        aluOut_MEM       = s.a;
        addrRt_MEM       = s.rta;
        dataRt_MEM       = s.rtd;
        regWriteAddr_MEM = s.wa;
        regWriteData_MEM = s.wd;
        Tnew_MEM         = s.tnew;
        regaddr_WB       = s.wba;
        regdata_WB       = s.wbd;
        e = '{default: '0};
        if (s.rst) begin
            foreach (mdl[i]) mdl[i] = 8'h00;
        end else if (s.clr) begin
            e = '{default: '0};
        end else if (s.stall) begin
            e = last;
        end else begin
            ld = 0; st = 0; sgn = 0; size = 1;
            case (s.op)
                I_LW:  begin ld = 1; size = 4; end
                I_LH:  begin ld = 1; size = 2; sgn = 1; end
                I_LHU: begin ld = 1; size = 2; end
                I_LB:  begin ld = 1; size = 1; sgn = 1; end
                I_LBU: begin ld = 1; size = 1; end
                I_SW:  begin st = 1; size = 4; end
                I_SH:  begin st = 1; size = 2; end
                I_SB:  begin st = 1; size = 1; end
                default: ;
            endcase
            a  = s.a;
            rt = (s.wba == s.rta && s.wba != 0) ? s.wbd : s.rtd;
            e.exc = s.exc;
            if (s.exc == 0 && (ld || st) && ((a % size) != 0 || a >= NB))
                e.exc = ld ? EXC_ADEL : EXC_ADES;
            e.instr = s.op;
            e.pc    = s.pc;
            e.tnew  = (s.tnew >= 1) ? s.tnew - 1 : '0;
            e.wa    = (ld && e.exc != 0) ? 5'd0 : s.wa;
            e.wd    = s.wd;
            if (ld) begin
                v = 0;
                if (e.exc == 0) begin
                    for (int k = 0; k < int'(size); k++) v[8*k +: 8] = mdl[a + k];
                    if (sgn && size == 2) v = {{16{v[15]}}, v[15:0]};
                    if (sgn && size == 1) v = {{24{v[7]}}, v[7:0]};
                end
                e.wd = v;
            end
            if (st && e.exc == 0 && !s.xr)
                for (int k = 0; k < int'(size); k++) mdl[a + k] = rt[8*k +: 8];
        end
        last = e;
        e.fa = (s.tnew == 0) ? s.wa : 5'd0;
        e.fd = s.wd;
        q.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("instr_WB", 32'(instr_WB), 32'(e.instr));
                chk("PC_WB", PC_WB, e.pc);
                chk("Exc_WB", 32'(Exc_WB), 32'(e.exc));
                chk("regWriteAddr_WB", 32'(regWriteAddr_WB), 32'(e.wa));
                chk("regWriteData_WB", regWriteData_WB, e.wd);
                chk("Tnew_WB", 32'(Tnew_WB), 32'(e.tnew));
                chk("regaddr_fwd", 32'(regaddr_fwd), 32'(e.fa));
                chk("regdata_fwd", regdata_fwd, e.fd);
            end
        end
    end

    function automatic logic [31:0] rnd_addr();
        int unsigned r;
        r = $urandom_range(0, 99);
        if (r < 75) return 32'($urandom_range(0, 63));
        if (r < 88) return 32'(NB - $urandom_range(1, 8));
        if (r < 95) return 32'(NB + $urandom_range(0, 16));
        return $urandom;
    endfunction

    initial begin : stimulus
        stim_t s;
        reset = 1; stall = 0; clr = 0; excReq = 0;
        instr_MEM = '0; PC_MEM = '0; Exc_MEM = '0; aluOut_MEM = '0;
        addrRt_MEM = '0; dataRt_MEM = '0; regWriteAddr_MEM = '0;
        regWriteData_MEM = '0; Tnew_MEM = '0; regaddr_WB = '0;
        regdata_WB = '0;
        last = '{default: '0};

        s = mk(I_NOP, 0, 0); s.wd = 0; s.tnew = 0; s.rst = 1;
        step(s);
        step(mk(I_SW, 32'h10, 32'hDEADBEEF));
        step(mk(I_LW, 32'h10, 0));
        step(mk(I_SW, 32'h10, 32'h11223344));
        step(mk(I_SB, 32'h13, 32'h000000A5));
        step(mk(I_LB, 32'h13, 0));
        step(mk(I_LBU, 32'h13, 0));
        step(mk(I_LW, 32'h10, 0));
        step(mk(I_LW, 32'h12, 0));
        step(mk(I_SH, 32'h11, 32'h0000BBBB));
        step(mk(I_LW, 32'h10, 0));
        step(mk(I_SW, 32'(NB), 32'h77777777));
        step(mk(I_LW, 32'h0, 0));
        s = mk(I_LW, 32'h12, 0); s.exc = 5'd12;
        step(s);
        s = mk(I_SW, 32'h20, 32'h1234); s.rta = 8; s.wba = 8; s.wbd = 32'h55;
        step(s);
        step(mk(I_LW, 32'h20, 0));
        s = mk(I_SW, 32'h20, 32'h1234); s.rta = 8; s.wba = 0; s.wbd = 32'h55;
        step(s);
        step(mk(I_LW, 32'h20, 0));
        step(mk(I_LH, 32'h22, 0));
        s = mk(I_SW, 32'h24, 32'hCAFEF00D); s.stall = 1;
        repeat (3) step(s);
        s.stall = 0;
        step(s);
        step(mk(I_LW, 32'h24, 0));
        s = mk(I_SW, 32'h24, 32'h0); s.xr = 1;
        step(s);
        step(mk(I_LW, 32'h24, 0));
        s = mk(I_SW, 32'h24, 32'h1); s.clr = 1; s.stall = 1;
        step(s);
        step(mk(I_LHU, 32'h26, 0));
        s = mk(I_LW, 32'h10, 0); s.rst = 1; s.stall = 1; s.clr = 1;
        step(s);
        step(mk(I_LW, 32'h10, 0));

        for (int n = 0; n < 1500; n++) begin
            s = mk(ops[$urandom_range(0, 9)], rnd_addr(), $urandom);
            if (s.op == I_ALU || is_ld(s.op)) s.wa = 5'($urandom_range(0, 31));
            s.rta = 5'($urandom_range(0, 3));
            s.wba = 5'($urandom_range(0, 3));
            s.wbd = $urandom;
            if ($urandom_range(0, 19) == 0) s.exc = 5'($urandom_range(1, 31));
            s.stall = ($urandom_range(0, 9) == 0);
            s.clr   = ($urandom_range(0, 19) == 0);
            s.xr    = ($urandom_range(0, 19) == 0);
            s.rst   = ($urandom_range(0, 499) == 0);
            step(s);
        end

        repeat (2) @(posedge clk);
        #2;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain actual=%0d required=0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
